// File: rtl/i2c_slave_responder.sv
// I2C slave responder: answers one 7-bit address, hands written bytes to the
// host side, and fetches read bytes from the host while stretching SCL.
module i2c_slave_responder #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o,
    output logic                      rw_o
);
    localparam int W  = I2C_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);  // 8th bit of a frame
    localparam logic [CW-1:0] ACKB = CW'(W);      // 9th (ACK) bit

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, STRETCH, READ, READ_ACK
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          first_q, first_n;   // skip the SCL fall that follows START
    logic [W-1:0]  sh_q, sh_n, sh_in;
    logic [W-1:0]  rd_sh_q, rd_sh_n;
    logic          sda_n, scl_n, rd_req_n, wr_valid_n, start_n, stop_n;
    logic          busy_n, rw_n;
    logic [W-1:0]  wr_data_n;

    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Two-flop synchronizers plus edge register; reset high to match an idle bus
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            {scl_s1, scl_s2, scl_d} <= {scl_i, scl_s1, scl_s2};
            {sda_s1, sda_s2, sda_d} <= {sda_i, sda_s1, sda_s2};
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign sh_in     = {sh_q[W-2:0], sda_s2};

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            sh_q       <= '0;
            rd_sh_q    <= '0;
            sda_o      <= 1'b1;
            scl_o      <= 1'b1;
            rd_req_o   <= 1'b0;
            wr_data_o  <= '0;
            wr_valid_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
            rw_o       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            first_q    <= first_n;
            sh_q       <= sh_n;
            rd_sh_q    <= rd_sh_n;
            sda_o      <= sda_n;
            scl_o      <= scl_n;
            rd_req_o   <= rd_req_n;
            wr_data_o  <= wr_data_n;
            wr_valid_o <= wr_valid_n;
            start_o    <= start_n;
            stop_o     <= stop_n;
            busy_o     <= busy_n;
            rw_o       <= rw_n;
        end
    end

    // Next-state logic; START beats STOP beats everything else
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        first_n    = first_q;
        sh_n       = sh_q;
        rd_sh_n    = rd_sh_q;
        sda_n      = sda_o;
        scl_n      = scl_o;
        rd_req_n   = rd_req_o;
        wr_data_n  = wr_data_o;
        wr_valid_n = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        busy_n     = busy_o;
        rw_n       = rw_o;

        // Bit counter advances on SCL falls, 0..8 then wraps
        if (scl_fall && state_q != IDLE) begin
            if (first_q)           first_n = 1'b0;
            else if (cnt_q == ACKB) cnt_n  = '0;
            else                    cnt_n  = cnt_q + 1'b1;
        end

        if (start_det) begin
            state_n  = ADDR;
            cnt_n    = '0;
            first_n  = 1'b1;
            start_n  = 1'b1;
            sda_n    = 1'b1;
            scl_n    = 1'b1;
            rd_req_n = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            sda_n    = 1'b1;
            scl_n    = 1'b1;
            rd_req_n = 1'b0;
            busy_n   = 1'b0;
            stop_n   = 1'b1;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_n = sh_in;
                    if (cnt_q == LAST) begin
                        if (sh_in[W-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                            rw_n    = sh_in[0];
                            busy_n  = 1'b1;
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                    if (cnt_q == LAST) begin
                        sda_n = 1'b0;
                    end else if (cnt_q == ACKB) begin
                        sda_n = 1'b1;
                        if (state_q == ADDR_ACK && rw_o) begin
                            state_n  = STRETCH;
                            scl_n    = 1'b0;
                            rd_req_n = 1'b1;
                        end else begin
                            state_n = WRITE;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    sh_n = sh_in;
                    if (cnt_q == LAST) begin
                        wr_data_n  = sh_in;
                        wr_valid_n = 1'b1;
                        state_n    = WRITE_ACK;
                    end
                end
                STRETCH: if (rd_req_o && rd_valid_i) begin
                    rd_sh_n  = rd_data_i << 1;
                    sda_n    = rd_data_i[W-1];
                    rd_req_n = 1'b0;
                    state_n  = READ;
                end
                READ: begin
                    // SCL is released one cycle after the MSB is on SDA
                    scl_n = 1'b1;
                    if (scl_fall) begin
                        if (cnt_q == LAST) begin
                            sda_n   = 1'b1;
                            state_n = READ_ACK;
                        end else begin
                            sda_n   = rd_sh_q[W-1];
                            rd_sh_n = rd_sh_q << 1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise && sda_s2) begin
                        state_n = IDLE;  // master NACK: stay busy until STOP/Sr
                    end else if (scl_fall && cnt_q == ACKB) begin
                        state_n  = STRETCH;
                        scl_n    = 1'b0;
                        rd_req_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
